// File: rtl/sp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sp_pkg
//  Description : Shared constants and filter state type for the ADC filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sp_pkg;

    localparam int ADC_W = 12;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } filt_state_e;

endpackage
`default_nettype wire

// File: rtl/adc_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_filter_if
//  Description : Sample-in / average-out bundle between XADC glue and filter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_filter_if #(
    parameter int ADC_W = sp_pkg::ADC_W
);
    logic             SAMPLE_VALID;
    logic [ADC_W-1:0] SAMPLE;
    logic             CLR;
    logic [ADC_W-1:0] V_AVG;
    logic             AVG_VALID;
    logic             FILLED;
    logic             SPIKE;

    modport master (
        output SAMPLE_VALID, SAMPLE, CLR,
        input  V_AVG, AVG_VALID, FILLED, SPIKE
    );

    modport slave (
        input  SAMPLE_VALID, SAMPLE, CLR,
        output V_AVG, AVG_VALID, FILLED, SPIKE
    );
endinterface
`default_nettype wire

// File: rtl/adc_filter_sample_ring.sv
`default_nettype none
// ============================================================================
//  Module      : sample_ring
//  Description : N x ADC_W sample store, synchronous write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_ring #(
    parameter int LOG2_N = 3,
    parameter int ADC_W  = sp_pkg::ADC_W
) (
    input  wire logic              clk_i,
    input  wire logic              we_i,
    input  wire logic [LOG2_N-1:0] addr_i,
    input  wire logic [ADC_W-1:0]  wdata_i,
    output logic      [ADC_W-1:0]  rdata_o
);
    localparam int N = 1 << LOG2_N;

    // No reset: every slot is rewritten during FILL before it is read in RUN.
    logic [ADC_W-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/adc_filter.sv
`default_nettype none
// ============================================================================
//  Module      : adc_filter
//  Description : Sliding-window (2^LOG2_N) average of XADC samples with
//                optional spike rejection (macro SPIKE_REJECT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_filter #(
    parameter int               LOG2_N   = 3,
    parameter int               ADC_W    = sp_pkg::ADC_W,
    parameter logic [ADC_W-1:0] SPIKE_TH = 12'h100,
    parameter int               MAX_REJ  = 3
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    adc_filter_if.slave bus
);
    import sp_pkg::*;

    localparam int               SUM_W    = ADC_W + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    filt_state_e       state_q;
    logic [LOG2_N-1:0] wp_q;
    logic [LOG2_N-1:0] cnt_q;
    logic [SUM_W-1:0]  sum_q;
    logic [ADC_W-1:0]  v_avg_q;
    logic              avg_valid_q;
    logic              filled_q;

    logic [ADC_W-1:0]  ring_rd;
    logic              reject_w;
    logic              accept_w;
    logic [SUM_W-1:0]  sample_ext;
    logic [SUM_W-1:0]  oldest_ext;
    logic [SUM_W-1:0]  sum_d;
    logic [ADC_W-1:0]  avg_d;

    sample_ring #(
        .LOG2_N (LOG2_N),
        .ADC_W  (ADC_W)
    ) u_ring (
        .clk_i   (CLK),
        .we_i    (accept_w),
        .addr_i  (wp_q),
        .wdata_i (bus.SAMPLE),
        .rdata_o (ring_rd)
    );

    assign accept_w = bus.SAMPLE_VALID & ~bus.CLR & ~reject_w;

    // The slot at wp holds the oldest sample once the window is full.
    always_comb begin
        sample_ext = {{LOG2_N{1'b0}}, bus.SAMPLE};
        oldest_ext = {{LOG2_N{1'b0}}, ring_rd};
        if (state_q == RUN) begin
            sum_d = sum_q + sample_ext - oldest_ext;
        end else begin
            sum_d = sum_q + sample_ext;
        end
        avg_d = sum_d[SUM_W-1:LOG2_N];
    end

`ifdef SPIKE_REJECT_EN
    localparam int               REJ_W     = (MAX_REJ < 1) ? 1 : $clog2(MAX_REJ + 1);
    localparam logic [REJ_W-1:0] MAX_REJ_C = REJ_W'(MAX_REJ);

    logic [REJ_W-1:0] rej_q;
    logic             spike_q;
    logic [ADC_W-1:0] diff_w;
    logic             oob_w;

    always_comb begin
        if (bus.SAMPLE >= v_avg_q) begin
            diff_w = bus.SAMPLE - v_avg_q;
        end else begin
            diff_w = v_avg_q - bus.SAMPLE;
        end
        oob_w    = (diff_w > SPIKE_TH);
        // Once MAX_REJ in a row are dropped, the next outlier is taken as a real step.
        reject_w = bus.SAMPLE_VALID & ~bus.CLR & (state_q == RUN) &
                   oob_w & (rej_q < MAX_REJ_C);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rej_q   <= '0;
            spike_q <= 1'b0;
        end else begin
            spike_q <= reject_w;
            if (bus.CLR || accept_w) begin
                rej_q <= '0;
            end else if (reject_w) begin
                rej_q <= rej_q + 1'b1;
            end
        end
    end

    assign bus.SPIKE = spike_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^{SPIKE_TH, MAX_REJ[0]};
    assign reject_w   = 1'b0;
    assign bus.SPIKE  = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= FILL;
            wp_q        <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            v_avg_q     <= '0;
            avg_valid_q <= 1'b0;
            filled_q    <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (bus.CLR) begin
                state_q  <= FILL;
                wp_q     <= '0;
                cnt_q    <= '0;
                sum_q    <= '0;
                filled_q <= 1'b0;
            end else if (accept_w) begin
                sum_q <= sum_d;
                wp_q  <= wp_q + 1'b1;
                case (state_q)
                    FILL: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q     <= RUN;
                            filled_q    <= 1'b1;
                            v_avg_q     <= avg_d;
                            avg_valid_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        v_avg_q     <= avg_d;
                        avg_valid_q <= 1'b1;
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign bus.V_AVG     = v_avg_q;
    assign bus.AVG_VALID = avg_valid_q;
    assign bus.FILLED    = filled_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_filter
//  Description : Self-checking bench for adc_filter against a window model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_filter;
    localparam int N        = 8;
    localparam int SPIKE_TH = 'h100;
    localparam int MAX_REJ  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adc_filter_if #(.ADC_W(12)) ifc ();

    adc_filter #(
        .LOG2_N   (3),
        .ADC_W    (12),
        .SPIKE_TH (12'h100),
        .MAX_REJ  (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (ifc.slave)
    );

    int n_chk   = 0;
    int n_fail  = 0;
    int pulses  = 0;
    int spikes  = 0;
    bit cmp_en  = 1'b0;

    // Model state: the window is simply the last N accepted samples.
    int q[$];
    int m_vavg   = 0;
    int m_avgv   = 0;
    int m_filled = 0;
    int m_spike  = 0;
    int m_rej    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int s;
        int d;
        int sum;
        bit rej;
        m_avgv  = 0;
        m_spike = 0;
        if (!rst) begin
            q.delete();
            m_vavg = 0; m_filled = 0; m_rej = 0;
        end else if (ifc.CLR) begin
            q.delete();
            m_filled = 0; m_rej = 0;
        end else if (ifc.SAMPLE_VALID) begin
            s   = int'(ifc.SAMPLE);
            rej = 1'b0;
`ifdef SPIKE_REJECT_EN
            if (q.size() == N) begin
                d = s - m_vavg;
                if (d < 0) d = -d;
                if (d > SPIKE_TH && m_rej < MAX_REJ) rej = 1'b1;
            end
`endif
            if (rej) begin
                m_spike = 1;
                m_rej++;
            end else begin
                m_rej = 0;
                q.push_back(s);
                if (q.size() > N) void'(q.pop_front());
                if (q.size() == N) begin
                    sum = 0;
                    foreach (q[i]) sum += q[i];
                    m_vavg   = sum / N;
                    m_avgv   = 1;
                    m_filled = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("V_AVG",     int'(ifc.V_AVG),     m_vavg);
            chk("AVG_VALID", int'(ifc.AVG_VALID), m_avgv);
            chk("FILLED",    int'(ifc.FILLED),    m_filled);
            chk("SPIKE",     int'(ifc.SPIKE),     m_spike);
            chk("NO_OVERLAP", int'(ifc.AVG_VALID & ifc.SPIKE), 0);
            if (ifc.AVG_VALID) pulses++;
            if (ifc.SPIKE) spikes++;
        end
    end

    task automatic cyc(input bit v, input int s, input bit c);
        @(posedge clk);
        #2;
        ifc.SAMPLE_VALID = v;
        ifc.SAMPLE       = 12'(s);
        ifc.CLR          = c;
    endtask

    task automatic send(input int s);
        cyc(1'b1, s, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 0, 1'b0);
    endtask

    initial begin
        ifc.SAMPLE_VALID = 1'b0;
        ifc.SAMPLE       = '0;
        ifc.CLR          = 1'b0;
        rst              = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        chk("reset V_AVG",  int'(ifc.V_AVG), 0);
        chk("reset FILLED", int'(ifc.FILLED), 0);
        chk("reset SPIKE",  int'(ifc.SPIKE), 0);
        rst = 1'b1;

        // Fill with 0x800: only the 8th sample produces a pulse.
        pulses = 0;
        repeat (8) send('h800);
        idle();
        chk("fill AVG_VALID", int'(ifc.AVG_VALID), 1);
        chk("fill V_AVG",     int'(ifc.V_AVG), 'h800);
        chk("fill FILLED",    int'(ifc.FILLED), 1);
        idle();
        chk("fill pulses",    pulses, 1);

`ifndef SPIKE_REJECT_EN
        send('hC00);
        idle();
        chk("step V_AVG", int'(ifc.V_AVG), 'h880);
`endif

        // CLR with a sample: sample dropped, average held.
        cyc(1'b1, 'h123, 1'b1);
        idle();
        chk("clr FILLED", int'(ifc.FILLED), 0);
`ifdef SPIKE_REJECT_EN
        chk("clr V_AVG hold", int'(ifc.V_AVG), 'h800);
`else
        chk("clr V_AVG hold", int'(ifc.V_AVG), 'h880);
`endif

        pulses = 0;
        for (int i = 0; i < 16; i++) send(i);
        idle();
        idle();
        chk("ramp pulses", pulses, 9);
        chk("ramp V_AVG",  int'(ifc.V_AVG), 'h00B);

        // Reset pulse mid-RUN while a sample is offered.
        send('h555);
        rst = 1'b0;
        idle();
        rst = 1'b1;
        chk("rst V_AVG",     int'(ifc.V_AVG), 0);
        chk("rst AVG_VALID", int'(ifc.AVG_VALID), 0);
        chk("rst FILLED",    int'(ifc.FILLED), 0);
        pulses = 0;
        repeat (7) send('h400);
        idle();
        chk("refill no pulse", pulses, 0);
        send('h400);
        idle();
        idle();
        chk("refill pulse", pulses, 1);

`ifdef SPIKE_REJECT_EN
        cyc(1'b0, 0, 1'b1);
        repeat (8) send('h800);
        idle();
        spikes = 0;
        repeat (4) send('hA00);
        idle();
        idle();
        chk("spike count", spikes, 3);
        chk("spike V_AVG", int'(ifc.V_AVG), 'h840);
`endif

        // Randomised traffic, occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            int s;
            if ($urandom_range(0, 1) == 0) s = 'h780 + int'($urandom_range(0, 'h100));
            else                            s = int'($urandom_range(0, 'hFFF));
            rst = ($urandom_range(0, 150) != 0);
            cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 60) == 0);
        end
        rst = 1'b1;
        idle();
        idle();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_filter.md
# adc_filter

Sliding-window averaging filter between the XADC conversion output and the max-tracking logic (voltage comparator and max-register array). It accepts one 12-bit sample per `SAMPLE_VALID` strobe, driven from XADC `drdy_out`/`adc_out`. It keeps the last 2^LOG2_N samples in a ring buffer with a running sum, and presents a registered average with a valid pulse. This prevents a single noisy conversion from being latched as the sweep maximum.

## Interface
- `LOG2_N`, 3: log2 of the window length N (N = 8 by default); legal range 1..6.
- `ADC_W`, 12: sample width.
- `SPIKE_TH`, 12'h100: rejection band, in LSBs. Used only with `SPIKE_REJECT_EN`.
- `MAX_REJ`, 3: maximum number of consecutive rejections. Used only with `SPIKE_REJECT_EN`.

Ports:
- `CLK`  in  1  system clock (pll_clk domain).
- `RST`  in  1  synchronous, active-low reset.
- `SAMPLE_VALID`  in  1  one-cycle strobe; `SAMPLE` is valid in this cycle.
- `SAMPLE`  in  ADC_W  raw conversion.
- `CLR`  in  1  synchronous flush of the window (from FSM `cnt_rst`).
- `V_AVG`  out  ADC_W  filtered value, registered.
- `AVG_VALID`  out  1  one-cycle pulse each time `V_AVG` is updated.
- `FILLED`  out  1  high while the window holds N accepted samples.
- `SPIKE`  out  1  one-cycle pulse when a sample is rejected; tied to 0 without the macro.

## Operation
- States:
  - `FILL`: the window is not yet full.
  - `RUN`: the window is full.
- Reset state: `FILL`, write pointer = 0, fill count = 0, sum = 0.
- Accept: a sample is accepted when `SAMPLE_VALID`=1, `CLR`=0 and the sample is not rejected.
- Accepted sample in `FILL`:
  - Write `buf[wp]`, sum += `SAMPLE`, wp++, count++.
  - On the Nth accepted sample (count = N-1 before the update), move to `RUN`, set `FILLED`=1 and pulse `AVG_VALID`.
  - Samples 1..N-1 do not update `V_AVG` and do not pulse `AVG_VALID`.
- Accepted sample in `RUN`:
  - sum = sum + `SAMPLE` - `buf[wp]`, then `buf[wp]` = `SAMPLE`, wp++.
  - `V_AVG` = sum_next >> LOG2_N, truncating; pulse `AVG_VALID`.
- Width rule: the sum register is ADC_W+LOG2_N bits and never overflows. The subtraction is performed at full width before the add result is registered.
- Pointer: wp is LOG2_N bits and wraps from N-1 to 0 with no special case.
- `CLR`=1:
  - Next state is `FILL`; wp, count and sum are cleared; `FILLED`=0.
  - `V_AVG` holds its last value.
  - Buffer contents are not cleared; they are overwritten during the next `FILL`.
- `CLR` and `SAMPLE_VALID` in the same cycle: `CLR` wins and the sample is discarded.
- `RST` low mid-operation: the next edge restores reset values regardless of `SAMPLE_VALID` and `CLR`.

## Timing
- Reset values: `V_AVG`=0, `AVG_VALID`=0, `FILLED`=0, `SPIKE`=0.
- Latency: a sample accepted at edge k appears on `V_AVG` with `AVG_VALID`=1 during cycle k+1.
- Throughput: one sample per cycle. Back-to-back `SAMPLE_VALID` is legal.
- `AVG_VALID` and `SPIKE` are never high in the same cycle.
- `FILLED` falls in the cycle after the edge that samples `CLR`.

## Configuration
- `SPIKE_REJECT_EN` defined:
  - In `RUN` only, a sample with |`SAMPLE` - `V_AVG`| > SPIKE_TH is rejected: no buffer write, `V_AVG` unchanged, `SPIKE` pulses, and the reject counter increments.
  - After MAX_REJ consecutive rejections, the next out-of-band sample is accepted unconditionally. This prevents lock-out after a genuine step.
  - Any accepted sample clears the reject counter; `CLR` and reset also clear it.
- `SPIKE_REJECT_EN` undefined: every valid sample is accepted, `SPIKE` is tied to 0, and `SPIKE_TH`/`MAX_REJ` are unused.

## Structure
- Shared package `sp_pkg`: the `ADC_W` constant and the filter state enum (`FILL`, `RUN`).
- One sub-module, `sample_ring`: an N×ADC_W register ring with a synchronous write port and an asynchronous read at wp. It contains no reset on storage.
- `adc_filter` holds the FSM, counters, sum datapath, spike logic and output registers.

## Test plan
- Reset, then 8 samples of 0x800 (LOG2_N=3): no `AVG_VALID` for samples 1-7. On the 8th, `AVG_VALID`=1 and `V_AVG`=0x800 in the following cycle, and `FILLED`=1.
- Full window of 0x800, then one 0xC00 (macro off): `V_AVG`=0x880.
- Ramp 0..15 back-to-back: 9 `AVG_VALID` pulses in total; final `V_AVG`=0x00B, which is the average of 8..15 truncated.
- `CLR` asserted together with `SAMPLE_VALID` in `RUN`: sample discarded, `FILLED`=0, `V_AVG` holds. The next 7 samples produce no pulse; the 8th produces one.
- `RST` driven low for 1 cycle mid-`RUN`: all outputs are 0 the next cycle, and a full 8-sample refill is required before the next pulse.
- Macro on, `SPIKE_TH`=0x100, average 0x800, `MAX_REJ`=3: three samples of 0xA00 each pulse `SPIKE` with `V_AVG` unchanged. The 4th is accepted, giving `V_AVG`=0x840.
